// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - opcodes, instruction classes and field helpers for pipeline_mips32
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam int OP_HI = 31, OP_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int IMM_HI = 15, IMM_LO = 0;

  typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} itype_t;

  function automatic itype_t decode(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BNEQZ, OP_BEQZ:                             return BRANCH;
      OP_HLT:                                        return HALT;
      default:                                       return NOP;
    endcase
  endfunction

  function automatic logic writes_reg(input itype_t t);
    return (t == RR_ALU) || (t == RM_ALU) || (t == LOAD);
  endfunction

  function automatic logic [31:0] sext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// rtl/mips32_alu.sv - combinational ALU; address arithmetic for LW/SW shares the add path
module mips32_alu
  import mips32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  opcode,
  output logic [31:0] result
);

  always_comb begin
    result = a + b;
    case (opcode)
      OP_SUB, OP_SUBI: result = a - b;
      OP_AND:          result = a & b;
      OP_OR:           result = a | b;
      OP_SLT, OP_SLTI: result = {31'b0, ($signed(a) < $signed(b))};
      OP_MUL:          result = a * b;
      default:         result = a + b;
    endcase
  end

endmodule

// File: rtl/pipeline_mips32.sv
// rtl/pipeline_mips32.sv - 5-stage MIPS32-subset pipeline with forwarding, load-use interlock and branch squash
module pipeline_mips32
  import mips32_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int MEM_AW    = 10
) (
  input  logic clk1,
  input  logic rst_n,
  output logic halted
);

  logic [31:0] memory  [0:MEM_WORDS-1];
  logic [31:0] regbank [0:31];
  logic [31:0] PC;
  logic        HALTED;
  logic        BRANCH_TAKEN;
  logic        halt_seen;

  logic        if_id_valid;
  logic [31:0] if_id_ir, if_id_npc;

  logic        id_ex_valid;
  itype_t      id_ex_type;
  logic [31:0] id_ex_ir, id_ex_npc, id_ex_a, id_ex_b, id_ex_imm;

  logic        ex_mem_valid;
  itype_t      ex_mem_type;
  logic [4:0]  ex_mem_dest;
  logic [31:0] ex_mem_alu, ex_mem_b;

  logic        mem_wb_valid;
  itype_t      mem_wb_type;
  logic [4:0]  mem_wb_dest;
  logic [31:0] mem_wb_val;

  assign halted = HALTED;

  // ID: decode and register read; WB writes are visible in the same cycle
  itype_t      id_type;
  logic [4:0]  id_rs, id_rt;
  logic        id_reads_rs, id_reads_rt, wb_we, load_use, id_hlt;
  logic [31:0] id_a, id_b;

  assign id_type     = decode(if_id_ir[OP_HI:OP_LO]);
  assign id_rs       = if_id_ir[RS_HI:RS_LO];
  assign id_rt       = if_id_ir[RT_HI:RT_LO];
  assign id_reads_rs = (id_type != HALT) && (id_type != NOP);
  assign id_reads_rt = (id_type == RR_ALU) || (id_type == STORE);
  assign wb_we       = mem_wb_valid && !HALTED && writes_reg(mem_wb_type) && (mem_wb_dest != 5'd0);

  always_comb begin
    id_a = regbank[id_rs];
    id_b = regbank[id_rt];
    if (id_rs == 5'd0) id_a = '0;
    else if (wb_we && mem_wb_dest == id_rs) id_a = mem_wb_val;
    if (id_rt == 5'd0) id_b = '0;
    else if (wb_we && mem_wb_dest == id_rt) id_b = mem_wb_val;
  end

  // EX: operand forwarding (EX/MEM before MEM/WB), ALU and branch resolution
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [5:0]  ex_op;
  logic        exm_fw, mwb_fw, taken;
  logic [31:0] fa, fb, alu_b, alu_out, target;

  assign ex_op   = id_ex_ir[OP_HI:OP_LO];
  assign ex_rs   = id_ex_ir[RS_HI:RS_LO];
  assign ex_rt   = id_ex_ir[RT_HI:RT_LO];
  assign ex_dest = (id_ex_type == RR_ALU) ? id_ex_ir[RD_HI:RD_LO] : ex_rt;
  assign exm_fw  = ex_mem_valid && (ex_mem_type == RR_ALU || ex_mem_type == RM_ALU) && (ex_mem_dest != 5'd0);
  assign mwb_fw  = mem_wb_valid && writes_reg(mem_wb_type) && (mem_wb_dest != 5'd0);

  always_comb begin
    fa = id_ex_a;
    fb = id_ex_b;
    if (exm_fw && ex_mem_dest == ex_rs) fa = ex_mem_alu;
    else if (mwb_fw && mem_wb_dest == ex_rs) fa = mem_wb_val;
    if (exm_fw && ex_mem_dest == ex_rt) fb = ex_mem_alu;
    else if (mwb_fw && mem_wb_dest == ex_rt) fb = mem_wb_val;
  end

  assign alu_b  = (id_ex_type == RR_ALU) ? fb : id_ex_imm;
  assign target = id_ex_npc + id_ex_imm;
  assign taken  = id_ex_valid && (id_ex_type == BRANCH) &&
                  ((ex_op == OP_BNEQZ && fa != '0) || (ex_op == OP_BEQZ && fa == '0));

  mips32_alu u_alu (
    .a      (fa),
    .b      (alu_b),
    .opcode (ex_op),
    .result (alu_out)
  );

  // The LW result only exists after MEM, so a consumer directly behind it must wait one cycle
  assign load_use = if_id_valid && id_ex_valid && (id_ex_type == LOAD) && (ex_rt != 5'd0) &&
                    ((id_reads_rs && id_rs == ex_rt) || (id_reads_rt && id_rt == ex_rt));
  assign id_hlt   = if_id_valid && (id_type == HALT) && !taken;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      BRANCH_TAKEN <= 1'b0;
      halt_seen    <= 1'b0;
      if_id_valid  <= 1'b0;
      if_id_ir     <= '0;
      if_id_npc    <= '0;
      id_ex_valid  <= 1'b0;
      id_ex_type   <= NOP;
      id_ex_ir     <= '0;
      id_ex_npc    <= '0;
      id_ex_a      <= '0;
      id_ex_b      <= '0;
      id_ex_imm    <= '0;
      ex_mem_valid <= 1'b0;
      ex_mem_type  <= NOP;
      ex_mem_dest  <= '0;
      ex_mem_alu   <= '0;
      ex_mem_b     <= '0;
      mem_wb_valid <= 1'b0;
      mem_wb_type  <= NOP;
      mem_wb_dest  <= '0;
      mem_wb_val   <= '0;
    end else begin
      BRANCH_TAKEN <= taken;
      if (taken) begin
        PC          <= target;
        if_id_valid <= 1'b0;
      end else if (load_use) begin
        PC <= PC;
      end else if (halt_seen || id_hlt) begin
        if_id_valid <= 1'b0;
      end else begin
        if_id_valid <= 1'b1;
        if_id_ir    <= memory[PC[MEM_AW-1:0]];
        if_id_npc   <= PC + 32'd1;
        PC          <= PC + 32'd1;
      end
      if (id_hlt) halt_seen <= 1'b1;

      id_ex_valid <= if_id_valid && !taken && !load_use;
      id_ex_type  <= id_type;
      id_ex_ir    <= if_id_ir;
      id_ex_npc   <= if_id_npc;
      id_ex_a     <= id_a;
      id_ex_b     <= id_b;
      id_ex_imm   <= sext(if_id_ir[IMM_HI:IMM_LO]);

      ex_mem_valid <= id_ex_valid;
      ex_mem_type  <= id_ex_type;
      ex_mem_dest  <= ex_dest;
      ex_mem_alu   <= alu_out;
      ex_mem_b     <= fb;

      mem_wb_valid <= ex_mem_valid;
      mem_wb_type  <= ex_mem_type;
      mem_wb_dest  <= ex_mem_dest;
      mem_wb_val   <= (ex_mem_type == LOAD) ? memory[ex_mem_alu[MEM_AW-1:0]] : ex_mem_alu;

      if (mem_wb_valid && mem_wb_type == HALT) HALTED <= 1'b1;
    end
  end

  // Architectural state is not reset; write enables derive from asynchronously cleared valids
  always_ff @(posedge clk1) begin
    if (wb_we) regbank[mem_wb_dest] <= mem_wb_val;
    if (ex_mem_valid && ex_mem_type == STORE && !HALTED)
      memory[ex_mem_alu[MEM_AW-1:0]] <= ex_mem_b;
  end

endmodule

// File: tb/tb_pipeline_mips32.sv
// tb/tb_pipeline_mips32.sv - directed and random-program checks of pipeline_mips32 against an ISA interpreter
module tb_pipeline_mips32;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  logic halted;

  int vectors = 0;
  int miscompares = 0;
  int cyc;
  int bt_count;

  logic [31:0] mr [32];
  logic [31:0] mm [1024];
  logic [31:0] prog [$];

  pipeline_mips32 dut (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .halted (halted)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    logic [4:0] d, s, t;
    d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
    return {op, s, t, d, 11'b0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
    logic [4:0] s, t;
    logic [15:0] i;
    s = rs[4:0]; t = rt[4:0]; i = imm[15:0];
    return {op, s, t, i};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic enter_reset();
    @(negedge clk1);
    rst_n = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) begin
      dut.memory[i] = prog[i];
      mm[i] = prog[i];
    end
  endtask

  task automatic run_prog(input string tag);
    #2;
    rst_n = 1'b1;
    cyc = 0;
    bt_count = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk1);
      #1;
      cyc++;
      if (dut.BRANCH_TAKEN === 1'b1) bt_count++;
      if (halted === 1'b1) break;
    end
    chk({tag, "_halted"}, {31'b0, halted}, 32'd1);
  endtask

  // Sequential ISA interpreter: one instruction at a time, no pipeline notion
  task automatic model_run();
    logic [31:0] pc, ir, a, b, imm, addr;
    logic [5:0]  op;
    logic [4:0]  rt, rd;
    pc = 0;
    for (int s = 0; s < 5000; s++) begin
      ir  = mm[pc[9:0]];
      op  = ir[31:26];
      rt  = ir[20:16];
      rd  = ir[15:11];
      a   = mr[ir[25:21]];
      b   = mr[rt];
      imm = {{16{ir[15]}}, ir[15:0]};
      addr = a + imm;
      pc  = pc + 1;
      if (op == 6'h3f) break;
      case (op)
        6'd0:  mr[rd] = a + b;
        6'd1:  mr[rd] = a - b;
        6'd2:  mr[rd] = a & b;
        6'd3:  mr[rd] = a | b;
        6'd4:  mr[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'd5:  mr[rd] = a * b;
        6'd10: mr[rt] = a + imm;
        6'd11: mr[rt] = a - imm;
        6'd12: mr[rt] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        6'd8:  mr[rt] = mm[addr[9:0]];
        6'd9:  mm[addr[9:0]] = b;
        6'd13: if (a != 0) pc = pc + imm;
        6'd14: if (a == 0) pc = pc + imm;
        default: ;
      endcase
      mr[0] = 32'd0;
    end
  endtask

  task automatic load_factorial();
    prog = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000,
             32'h14431000, 32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe,
             32'hfc000000};
    load_prog();
    for (int k = 0; k < 32; k++) dut.regbank[k] = k;
    dut.memory[200] = 32'd7;
    dut.memory[198] = 32'd0;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_pc", dut.PC, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_bt", {31'b0, dut.BRANCH_TAKEN}, 32'd0);

    // factorial
    load_factorial();
    run_prog("fact");
    chk("fact_m198", dut.memory[198], 32'd5040);
    chk("fact_r2", dut.regbank[2], 32'd5040);
    chk("fact_r3", dut.regbank[3], 32'd0);
    chk("fact_r10", dut.regbank[10], 32'd200);
    repeat (20) @(posedge clk1);
    #1;
    chk("post_halt_pc", dut.PC, 32'd11);
    chk("post_halt_m198", dut.memory[198], 32'd5040);
    chk("post_halt_r2", dut.regbank[2], 32'd5040);
    chk("post_halt_flag", {31'b0, halted}, 32'd1);

    // back-to-back forwarding
    enter_reset();
    prog = '{ri(6'd10, 1, 0, 5), rr(6'd0, 2, 1, 1), rr(6'd1, 3, 2, 1), 32'hfc000000};
    load_prog();
    for (int k = 1; k < 4; k++) dut.regbank[k] = 32'hdead0000 + k;
    run_prog("fwd");
    chk("fwd_r2", dut.regbank[2], 32'd10);
    chk("fwd_r3", dut.regbank[3], 32'd5);
    chk("fwd_cycles", cyc, 32'd8);

    // load-use interlock
    enter_reset();
    prog = '{ri(6'd8, 4, 0, 50), rr(6'd0, 5, 4, 4), 32'hfc000000};
    load_prog();
    dut.memory[50] = 32'd9;
    dut.regbank[4] = 32'd1;
    dut.regbank[5] = 32'd1;
    run_prog("lu");
    chk("lu_r5", dut.regbank[5], 32'd18);
    chk("lu_cycles", cyc, 32'd8);

    // branch squash
    enter_reset();
    prog = '{ri(6'd14, 0, 0, 2), ri(6'd10, 6, 0, 1), ri(6'd10, 7, 0, 1), ri(6'd10, 8, 0, 3), 32'hfc000000};
    load_prog();
    for (int k = 6; k < 9; k++) dut.regbank[k] = 32'd0;
    run_prog("br");
    chk("br_r6", dut.regbank[6], 32'd0);
    chk("br_r7", dut.regbank[7], 32'd0);
    chk("br_r8", dut.regbank[8], 32'd3);
    chk("br_pulses", bt_count, 32'd1);

    // signed ops and R0
    enter_reset();
    prog = '{ri(6'd12, 9, 0, -1), ri(6'd11, 11, 0, 1), ri(6'd10, 0, 0, 7), 32'hfc000000};
    load_prog();
    dut.regbank[0] = 32'd0;
    dut.regbank[9] = 32'd5;
    dut.regbank[11] = 32'd5;
    run_prog("sgn");
    chk("sgn_r9", dut.regbank[9], 32'd0);
    chk("sgn_r11", dut.regbank[11], 32'hffffffff);
    chk("sgn_r0", dut.regbank[0], 32'd0);

    // reset in the middle of the factorial loop
    enter_reset();
    load_factorial();
    #2;
    rst_n = 1'b1;
    repeat (15) @(posedge clk1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_pc", dut.PC, 32'd0);
    chk("mid_halted", {31'b0, halted}, 32'd0);
    chk("mid_pipe", {28'b0, dut.if_id_valid, dut.id_ex_valid, dut.ex_mem_valid, dut.mem_wb_valid}, 32'd0);
    chk("mid_m198", dut.memory[198], 32'd0);
    @(negedge clk1);
    run_prog("rerun");
    chk("rerun_m198", dut.memory[198], 32'd5040);
    chk("rerun_r2", dut.regbank[2], 32'd5040);
    chk("rerun_r3", dut.regbank[3], 32'd0);

    // random hazard-dense programs with forward-only branches
    for (int t = 0; t < 6; t++) begin
      int n;
      n = 24;
      enter_reset();
      prog.delete();
      for (int i = 0; i < n; i++) begin
        int kind, lim;
        kind = $urandom_range(0, 9);
        lim = (n - 1 - i < 3) ? n - 1 - i : 3;
        case (kind)
          0, 1, 2, 3: prog.push_back(rr(6'($urandom_range(0, 5)), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
          4, 5:       prog.push_back(ri(6'($urandom_range(10, 12)), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535)));
          6:          prog.push_back(ri(6'd8, $urandom_range(0, 7), 0, 300 + $urandom_range(0, 15)));
          7:          prog.push_back(ri(6'd9, $urandom_range(0, 7), 0, 300 + $urandom_range(0, 15)));
          8:          prog.push_back(ri(6'($urandom_range(13, 14)), 0, $urandom_range(0, 7), $urandom_range(0, lim)));
          default:    prog.push_back(32'h80000000 | $urandom_range(0, 65535));
        endcase
      end
      prog.push_back(32'hfc000000);
      load_prog();
      mr[0] = 32'd0;
      dut.regbank[0] = 32'd0;
      for (int k = 1; k < 8; k++) begin
        mr[k] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        dut.regbank[k] = mr[k];
      end
      for (int j = 300; j < 316; j++) begin
        mm[j] = $urandom;
        dut.memory[j] = mm[j];
      end
      model_run();
      run_prog($sformatf("rnd%0d", t));
      for (int k = 0; k < 8; k++) chk($sformatf("rnd%0d_r%0d", t, k), dut.regbank[k], mr[k]);
      for (int j = 300; j < 316; j++) chk($sformatf("rnd%0d_m%0d", t, j), dut.memory[j], mm[j]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
